// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared UART data width and issue-FSM state encodings
package uart_tx_fifo_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer push port plus uart_tx start/data/busy handshake
interface uart_tx_fifo_if #(parameter int ADDR_W = 4);
    import uart_tx_fifo_pkg::*;
    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [ADDR_W:0]        count;
    logic                   overflow;
    logic                   ovf_clr;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    modport master (
        output wr_en, wr_data, ovf_clr, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_data
    );
    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_busy,
        output full, empty, count, overflow, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: generic register-array FIFO with first-word-fall-through read
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_ok, rd_ok;
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign full    = count == (ADDR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding uart_tx one frame at a time via start/busy
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    tx_state_e              state, state_n;
    logic                   pop, drop, start_n, ovf_n;
    logic [UART_DATA_W-1:0] head, data_n;
    sync_fifo #(.DATA_W(UART_DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (bus.full),
        .empty   (bus.empty),
        .count   (bus.count)
    );
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
    end
    always_comb begin
        state_n = (state == ST_IDLE && pop)                ? ST_WAIT_ACK  :
                  (state == ST_WAIT_ACK && bus.tx_busy)    ? ST_WAIT_DONE :
                  (state == ST_WAIT_DONE && !bus.tx_busy)  ? ST_IDLE      : state;
    end
    // a drop on a full FIFO outranks a same-cycle overflow clear
    always_comb begin
        pop     = state == ST_IDLE && !bus.empty && !bus.tx_busy;
        start_n = pop;
        data_n  = pop ? head : bus.tx_data;
        drop    = bus.wr_en && bus.full && !pop;
        ovf_n   = drop | (bus.overflow & ~bus.ovf_clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.tx_start <= start_n;
            bus.tx_data  <= data_n;
            bus.overflow <= ovf_n;
        end
    end
endmodule
